// File: rtl/imm_ext_stage_if.sv
// Handshake bundle for the ID->EX immediate-extension stage.
// The stage uses the slave modport and the decode side drives the master modport.
interface imm_ext_stage_if #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32,
  parameter int TAG_W = 5
);
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [5:0]       in_opcode;
  logic [IN_W-1:0]  in_imm;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_imm;
  logic [TAG_W-1:0] out_tag;

  modport master (
    output flush, in_valid, in_opcode, in_imm, in_tag, out_ready,
    input  in_ready, out_valid, out_imm, out_tag
  );

  modport slave (
    input  flush, in_valid, in_opcode, in_imm, in_tag, out_ready,
    output in_ready, out_valid, out_imm, out_tag
  );
endinterface

// File: rtl/imm_ext_stage.sv
// Registered immediate-extension stage with a 2-entry skid buffer (ID->EX).
// Define IMM_EXT_BRSHIFT_EN to make beq/bne emit a byte offset (sign-extended imm << 2).
module imm_ext_stage #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32,
  parameter int TAG_W = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  imm_ext_stage_if.slave bus
);

  localparam int PAD_W = OUT_W - IN_W;

  typedef enum logic [1:0] {
    MODE_SIGN,
    MODE_ZERO,
    MODE_UPPER,
    MODE_BRANCH
  } mode_e;

  typedef enum logic [1:0] {
    EMPTY,
    ONE,
    TWO
  } state_e;

  state_e           state;
  logic             in_ready_q;
  logic             out_valid_q;
  logic [OUT_W-1:0] head_imm;
  logic [TAG_W-1:0] head_tag;
  logic [OUT_W-1:0] skid_imm;
  logic [TAG_W-1:0] skid_tag;

  mode_e            mode;
  logic [OUT_W-1:0] sign_ext;
  logic [OUT_W-1:0] ext_imm;
  logic             push;
  logic             pop;

  assign push = bus.in_valid & in_ready_q;
  assign pop  = out_valid_q & bus.out_ready;

  // NOTE: every always_comb output gets a default before the case so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    mode = MODE_SIGN;
    case (bus.in_opcode)
      6'b001100, 6'b001101, 6'b001110: mode = MODE_ZERO;   // andi/ori/xori
      6'b001111:                       mode = MODE_UPPER;  // lui
      6'b000100, 6'b000101:            mode = MODE_BRANCH; // beq/bne
      default:                         mode = MODE_SIGN;
    endcase
  end

  assign sign_ext = {{PAD_W{bus.in_imm[IN_W-1]}}, bus.in_imm};

  always_comb begin
    ext_imm = sign_ext;
    case (mode)
      MODE_ZERO:   ext_imm = {{PAD_W{1'b0}}, bus.in_imm};
      MODE_UPPER:  ext_imm = {bus.in_imm, {PAD_W{1'b0}}};
`ifdef IMM_EXT_BRSHIFT_EN
      MODE_BRANCH: ext_imm = sign_ext << 2;
`else
      MODE_BRANCH: ext_imm = sign_ext;
`endif
      default:     ext_imm = sign_ext;
    endcase
  end

  // Occupancy FSM; in_ready/out_valid are loaded from the next state so they
  // are flops yet always agree with the occupancy.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= EMPTY;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      head_imm    <= '0;
      head_tag    <= '0;
    end else if (bus.flush) begin
      state       <= EMPTY;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state)
        EMPTY: begin
          if (push) begin
            state       <= ONE;
            out_valid_q <= 1'b1;
            head_imm    <= ext_imm;
            head_tag    <= bus.in_tag;
          end
        end
        ONE: begin
          if (push && pop) begin
            head_imm <= ext_imm;
            head_tag <= bus.in_tag;
          end else if (push) begin
            state      <= TWO;
            in_ready_q <= 1'b0;
          end else if (pop) begin
            state       <= EMPTY;
            out_valid_q <= 1'b0;
          end
        end
        TWO: begin
          if (pop) begin
            state      <= ONE;
            in_ready_q <= 1'b1;
            head_imm   <= skid_imm;
            head_tag   <= skid_tag;
          end
        end
        default: begin
          state       <= EMPTY;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  // NOTE: the skid entry is pure datapath and is only read once the FSM has
  // marked it occupied, so it carries no reset.
  always_ff @(posedge clk) begin
    if (!bus.flush && state == ONE && push && !pop) begin
      skid_imm <= ext_imm;
      skid_tag <= bus.in_tag;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_imm   = head_imm;
  assign bus.out_tag   = head_tag;

endmodule

// File: tb/tb_imm_ext_stage.sv
// Self-checking bench for imm_ext_stage: directed scenarios plus randomized
// traffic against a queue-based reference of a 2-deep FIFO.
module tb_imm_ext_stage;

  localparam int IN_W  = 16;
  localparam int OUT_W = 32;
  localparam int TAG_W = 5;

  typedef struct {
    logic [OUT_W-1:0] imm;
    logic [TAG_W-1:0] tag;
  } beat_t;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;
  beat_t q[$];

  imm_ext_stage_if #(.IN_W(IN_W), .OUT_W(OUT_W), .TAG_W(TAG_W)) bus ();

  imm_ext_stage #(.IN_W(IN_W), .OUT_W(OUT_W), .TAG_W(TAG_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference extension from the opcode rules, using plain integer arithmetic.
  function automatic logic [OUT_W-1:0] ref_ext(input logic [5:0] op, input logic [IN_W-1:0] imm);
    longint u;
    longint s;
    u = longint'(imm);
    s = imm[IN_W-1] ? u - (longint'(1) << IN_W) : u;
    case (op)
      6'b001100, 6'b001101, 6'b001110: return OUT_W'(u);
      6'b001111:                       return OUT_W'(u * (longint'(1) << (OUT_W - IN_W)));
`ifdef IMM_EXT_BRSHIFT_EN
      6'b000100, 6'b000101:            return OUT_W'(s * 4);
`else
      6'b000100, 6'b000101:            return OUT_W'(s);
`endif
      default:                         return OUT_W'(s);
    endcase
  endfunction

  task automatic drive(input logic v, input logic [5:0] op, input logic [IN_W-1:0] imm,
                       input logic [TAG_W-1:0] tag, input logic ordy, input logic fl);
    bus.in_valid  = v;
    bus.in_opcode = op;
    bus.in_imm    = imm;
    bus.in_tag    = tag;
    bus.out_ready = ordy;
    bus.flush     = fl;
  endtask

  task automatic compare_model();
    check("out_valid", 64'(bus.out_valid), 64'(q.size() != 0));
    check("in_ready", 64'(bus.in_ready), 64'(q.size() < 2));
    if (q.size() != 0) begin
      check("out_imm", 64'(bus.out_imm), 64'(q[0].imm));
      check("out_tag", 64'(bus.out_tag), 64'(q[0].tag));
    end
  endtask

  // One clock: decide push/pop from the model's pre-edge occupancy, advance the model, then compare.
  task automatic cycle();
    bit    mpush;
    bit    mpop;
    beat_t b;
    mpush = bus.in_valid && (q.size() < 2);
    mpop  = (q.size() != 0) && bus.out_ready;
    b.imm = ref_ext(bus.in_opcode, bus.in_imm);
    b.tag = bus.in_tag;
    @(posedge clk);
    if (bus.flush) q.delete();
    else begin
      if (mpop) q.delete(0);
      if (mpush) q.push_back(b);
    end
    #1;
    compare_model();
  endtask

  logic [5:0] ops [9] = '{6'b001000, 6'b001100, 6'b001101, 6'b001110, 6'b001111,
                          6'b000100, 6'b000101, 6'b100011, 6'b000000};

  initial begin
    logic [OUT_W-1:0] br_exp;
    n_tests = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    drive(1'b0, 6'd0, '0, '0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);
    check("rst_out_imm", 64'(bus.out_imm), 64'd0);
    check("rst_out_tag", 64'(bus.out_tag), 64'd0);
    rst_n = 1'b1;

    // Sign, zero, upper and branch extensions with a consuming downstream
    drive(1'b1, 6'b001000, 16'h8001, 5'd3, 1'b1, 1'b0);
    cycle();
    check("t1_valid", 64'(bus.out_valid), 64'd1);
    check("t1_imm", 64'(bus.out_imm), 64'hFFFF8001);
    check("t1_tag", 64'(bus.out_tag), 64'd3);
    drive(1'b1, 6'b001100, 16'h8001, 5'd4, 1'b1, 1'b0);
    cycle();
    check("t2_zero", 64'(bus.out_imm), 64'h00008001);
    drive(1'b1, 6'b001111, 16'h1234, 5'd5, 1'b1, 1'b0);
    cycle();
    check("t2_lui", 64'(bus.out_imm), 64'h12340000);
    drive(1'b1, 6'b000100, 16'hFFFF, 5'd6, 1'b1, 1'b0);
    cycle();
`ifdef IMM_EXT_BRSHIFT_EN
    br_exp = 32'hFFFFFFFC;
`else
    br_exp = 32'hFFFFFFFF;
`endif
    check("t3_beq", 64'(bus.out_imm), 64'(br_exp));
    drive(1'b0, 6'd0, '0, '0, 1'b1, 1'b0);
    cycle();

    // Back-pressure: three offered beats, only two accepted, then drain in order
    drive(1'b1, 6'b001000, 16'h0010, 5'd10, 1'b0, 1'b0);
    cycle();
    drive(1'b1, 6'b001101, 16'h0011, 5'd11, 1'b0, 1'b0);
    cycle();
    check("t4_full_ready", 64'(bus.in_ready), 64'd0);
    drive(1'b1, 6'b001110, 16'h0012, 5'd12, 1'b0, 1'b0);
    cycle();
    check("t4_head_tag", 64'(bus.out_tag), 64'd10);
    drive(1'b0, 6'd0, '0, '0, 1'b1, 1'b0);
    cycle();
    check("t4_second_tag", 64'(bus.out_tag), 64'd11);
    cycle();
    check("t4_drained", 64'(bus.out_valid), 64'd0);

    // Flush while full with a concurrent push
    drive(1'b1, 6'b001000, 16'h0100, 5'd1, 1'b0, 1'b0);
    cycle();
    drive(1'b1, 6'b001000, 16'h0200, 5'd2, 1'b0, 1'b0);
    cycle();
    drive(1'b1, 6'b001000, 16'h0300, 5'd20, 1'b0, 1'b1);
    cycle();
    check("t5_flush_valid", 64'(bus.out_valid), 64'd0);
    check("t5_flush_ready", 64'(bus.in_ready), 64'd1);
    drive(1'b1, 6'b001000, 16'h0400, 5'd21, 1'b1, 1'b0);
    cycle();
    check("t5_first_after", 64'(bus.out_tag), 64'd21);

    // Asynchronous reset mid-stream with one beat held
    drive(1'b0, 6'd0, '0, '0, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_valid", 64'(bus.out_valid), 64'd0);
    check("t6_imm", 64'(bus.out_imm), 64'd0);
    check("t6_tag", 64'(bus.out_tag), 64'd0);
    check("t6_ready", 64'(bus.in_ready), 64'd1);
    q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive(1'b1, 6'b001100, 16'hBEEF, 5'd7, 1'b1, 1'b0);
    cycle();
    check("t6_resume", 64'(bus.out_imm), 64'h0000BEEF);

    // Randomized traffic against the reference FIFO
    for (int i = 0; i < 3000; i++) begin
      logic [5:0] op;
      op = ($urandom_range(3) == 0) ? 6'($urandom) : ops[$urandom_range(8)];
      drive(1'($urandom), op, IN_W'($urandom), TAG_W'($urandom),
            1'($urandom_range(3) != 0), 1'($urandom_range(31) == 0));
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
